flipdot_frame_tx: RTL and testbench

- Downstream stage of ball_detector. Serialises one flipdot panel frame as 8N1 UART on txd.
- Holds a column buffer that the detector writes: 28 columns × 7 dots.
- On a send request it emits one panel packet: header, command, address, 28 column bytes, end byte.
- Runs entirely in the uclk (UART baud) domain.

---
 rtl/flipdot_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_flipdot_frame_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flipdot_frame_tx.sv
// flipdot_frame_tx: serialises one flipdot panel frame (header, command,
// address, NUM_COLS column bytes, end byte) as back-to-back 8N1 UART on txd.
// A shadow column buffer accepts writes at any time. It is copied whole into
// the active buffer in the cycle a packet starts.
module flipdot_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned NUM_COLS     = 28,
  parameter logic [7:0]  PANEL_ADDR   = 8'hFF,
  parameter logic [7:0]  CMD_BYTE     = 8'h83
) (
  input  logic       uclk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [6:0] wr_data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  typedef enum logic [2:0] {IDLE, HDR, CMD, ADDR, DATA, EOF} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0] COL_LAST  = 5'(NUM_COLS - 1);
  localparam logic [5:0] COL_LIMIT = 6'(NUM_COLS);

  logic [6:0] shadow [NUM_COLS];
  logic [6:0] active [NUM_COLS];

  state_t     state, state_n;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [4:0] col_idx;
  logic       pending;
  logic       fin, fin_n;
  logic       start_pkt;
  logic       bit_end, byte_end;
  logic [7:0] cur_byte;
  logic       txd_n;

  assign bit_end  = (div_cnt == DIV_LAST);
  assign byte_end = bit_end && (bit_cnt == 4'd9);

  // Next-state logic: one state per packet section, advancing on stop-bit end.
  always_comb begin
    state_n   = state;
    start_pkt = 1'b0;
    fin_n     = 1'b0;
    case (state)
      IDLE: begin
        if (send || pending) begin
          state_n   = HDR;
          start_pkt = 1'b1;
        end
      end
      HDR:  if (byte_end) state_n = CMD;
      CMD:  if (byte_end) state_n = ADDR;
      ADDR: if (byte_end) state_n = DATA;
      DATA: if (byte_end && (col_idx == COL_LAST)) state_n = EOF;
      EOF: begin
        if (byte_end) begin
          state_n = IDLE;
          fin_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte currently on the wire and the bit level it produces.
  always_comb begin
    cur_byte = 8'hFF;
    case (state)
      HDR:     cur_byte = 8'h80;
      CMD:     cur_byte = CMD_BYTE;
      ADDR:    cur_byte = PANEL_ADDR;
      DATA:    cur_byte = {1'b0, active[col_idx]};
      EOF:     cur_byte = 8'h8F;
      default: cur_byte = 8'hFF;
    endcase
    txd_n = 1'b1;
    if (state != IDLE) begin
      if (bit_cnt == 4'd0)
        txd_n = 1'b0;
      else if (bit_cnt <= 4'd8)
        txd_n = cur_byte[3'(bit_cnt - 4'd1)];
      else
        txd_n = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Baud divider, bit-within-byte counter and column index.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      col_idx <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      col_idx <= '0;
    end else if (bit_end) begin
      div_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        bit_cnt <= '0;
        if ((state == DATA) && (col_idx != COL_LAST))
          col_idx <= col_idx + 5'd1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // One-deep send request latch; cleared when the packet it asked for starts.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset)                        pending <= 1'b0;
    else if (start_pkt)               pending <= 1'b0;
    else if (send && (state != IDLE)) pending <= 1'b1;
  end

  // Shadow buffer: host writes, out-of-range columns dropped.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_COLS; i++) shadow[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < COL_LIMIT)) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // Active buffer: snapshot of shadow taken as the packet starts, so a write
  // in that same cycle lands only in shadow and goes out next time.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_COLS; i++) active[i] <= '0;
    end else if (start_pkt) begin
      for (int unsigned i = 0; i < NUM_COLS; i++) active[i] <= shadow[i];
    end
  end

  // Registered outputs, one cycle behind the FSM. fin marks the first idle
  // cycle after a packet, so done appears together with busy falling, and a
  // pending restart in that cycle costs exactly one idle bit time on txd.
  always_ff @(posedge uclk or posedge reset) begin
    if (reset) begin
      txd  <= 1'b1;
      busy <= 1'b0;
      fin  <= 1'b0;
      done <= 1'b0;
    end else begin
      txd  <= txd_n;
      busy <= (state != IDLE);
      fin  <= fin_n;
      done <= fin;
    end
  end

endmodule

// File: tb/tb_flipdot_frame_tx.sv
// Testbench for flipdot_frame_tx: two instances (1 and 4 clocks per bit),
// UART monitors decoding txd against a byte scoreboard, plus timing checks.
module tb_flipdot_frame_tx;

  localparam int NC = 28;

  logic       uclk;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [6:0] wr_data;
  logic       send1, send4;
  logic       busy1, done1, txd1;
  logic       busy4, done4, txd4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0] model [NC];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] rx_bytes0[$];
  int rxcnt0 = 0;
  int rxcnt1 = 0;

  typedef struct {
    logic [4:0] addr;
    logic [6:0] data;
    int         chk_col;
    logic [7:0] chk_val;
  } vec_t;
  vec_t vecs[5];

  flipdot_frame_tx #(.CLKS_PER_BIT(1), .NUM_COLS(NC), .PANEL_ADDR(8'hFF), .CMD_BYTE(8'h83)) dut1 (
    .uclk(uclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .send(send1), .busy(busy1), .done(done1), .txd(txd1));

  flipdot_frame_tx #(.CLKS_PER_BIT(4), .NUM_COLS(NC), .PANEL_ADDR(8'hFF), .CMD_BYTE(8'h83)) dut4 (
    .uclk(uclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .send(send4), .busy(busy4), .done(done4), .txd(txd4));

  initial begin
    uclk = 1'b0;
    forever #5 uclk = ~uclk;
  end

  always @(posedge uclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic txd_of(input int id);
    return (id == 0) ? txd1 : txd4;
  endfunction
  function automatic logic busy_of(input int id);
    return (id == 0) ? busy1 : busy4;
  endfunction
  function automatic logic done_of(input int id);
    return (id == 0) ? done1 : done4;
  endfunction
  function automatic int exp_size(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction
  function automatic int rx_count(input int id);
    return (id == 0) ? rxcnt0 : rxcnt1;
  endfunction

  task automatic tick;
    @(posedge uclk);
    #1;
  endtask

  // Scoreboard side of the monitor: compare one decoded byte.
  task automatic got_byte(input int id, input logic [7:0] b, input bit bad);
    logic [7:0] e;
    check("framing", int'(bad), 0);
    check("sb_nonempty", int'(exp_size(id) > 0), 1);
    if (id == 0) begin
      e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'h00;
      rx_bytes0.push_back(b);
      rxcnt0++;
    end else begin
      e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'h00;
      rxcnt1++;
    end
    check("byte", int'(b), int'(e));
  endtask

  // UART monitor: samples every negedge, requires each bit stable for p cycles.
  task automatic mon(input int id, input int p);
    logic [7:0] b;
    logic       v, first;
    bit         bad, ab;
    forever begin
      @(negedge uclk);
      if (reset || txd_of(id)) continue;
      bad = 0; ab = 0; b = '0; first = 1'b0;
      for (int bi = 0; bi < 10; bi++) begin
        for (int s = 0; s < p; s++) begin
          if (bi != 0 || s != 0) @(negedge uclk);
          v = txd_of(id);
          if (reset) ab = 1;
          if (s == 0) first = v;
          else if (v != first) bad = 1;
        end
        if (bi == 0 && first != 1'b0) bad = 1;
        if (bi == 9 && first != 1'b1) bad = 1;
        if (bi >= 1 && bi <= 8) b[bi-1] = first;
      end
      if (!ab) got_byte(id, b, bad);
    end
  endtask

  initial mon(0, 1);
  initial mon(1, 4);

  task automatic push_frame(input int id);
    logic [7:0] f[$];
    f.push_back(8'h80);
    f.push_back(8'h83);
    f.push_back(8'hFF);
    for (int c = 0; c < NC; c++) f.push_back({1'b0, model[c]});
    f.push_back(8'h8F);
    foreach (f[i]) begin
      if (id == 0) exp_q0.push_back(f[i]);
      else         exp_q1.push_back(f[i]);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
    if (int'(a) < NC) model[a] = d;
  endtask

  task automatic start(input int id, output int k);
    push_frame(id);
    if (id == 0) send1 = 1'b1; else send4 = 1'b1;
    tick;
    send1 = 1'b0; send4 = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int id, input int p, output int t, output bit gap);
    int lim;
    lim = 10 * (NC + 4) * p + 40;
    gap = 0; t = -1;
    for (int n = 0; n < lim; n++) begin
      tick;
      if (done_of(id)) begin
        t = cyc;
        break;
      end
      if (!busy_of(id)) gap = 1;
    end
    check("done_seen", int'(t >= 0), 1);
  endtask

  task automatic run_frame(input int id, input int p);
    int k, t, c0;
    bit gap;
    c0 = rx_count(id);
    start(id, k);
    tick;
    check("start_bit", int'(txd_of(id)), 0);
    check("busy_at_start", int'(busy_of(id)), 1);
    wait_done(id, p, t, gap);
    check("done_latency", t - k, 10 * (NC + 4) * p + 1);
    check("busy_gap", int'(gap), 0);
    check("busy_with_done", int'(busy_of(id)), 0);
    check("txd_idle_at_done", int'(txd_of(id)), 1);
    tick;
    check("done_one_cycle", int'(done_of(id)), 0);
    check("sb_drained", exp_size(id), 0);
    check("byte_count", rx_count(id) - c0, NC + 4);
  endtask

  initial begin : main
    int k, t, t2, c0, dc;
    bit gap;

    vecs[0] = '{addr: 5'd0,  data: 7'h7F, chk_col: 0,  chk_val: 8'h7F};
    vecs[1] = '{addr: 5'd27, data: 7'h01, chk_col: 27, chk_val: 8'h01};
    vecs[2] = '{addr: 5'd13, data: 7'h2A, chk_col: 13, chk_val: 8'h2A};
    vecs[3] = '{addr: 5'd28, data: 7'h7F, chk_col: 27, chk_val: 8'h01};
    vecs[4] = '{addr: 5'd31, data: 7'h55, chk_col: 0,  chk_val: 8'h7F};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; send1 = 1'b0; send4 = 1'b0;
    for (int c = 0; c < NC; c++) model[c] = '0;
    repeat (3) tick;
    check("rst_txd1", int'(txd1), 1);
    check("rst_busy1", int'(busy1), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_txd4", int'(txd4), 1);
    check("rst_busy4", int'(busy4), 0);
    check("rst_done4", int'(done4), 0);
    reset = 1'b0;
    repeat (2) tick;

    // Empty buffer frame, then out-of-range write must not change it.
    run_frame(0, 1);
    wr(5'd28, 7'h7F);
    c0 = rxcnt0;
    run_frame(0, 1);
    repeat (30) tick;
    check("no_extra_byte", rxcnt0 - c0, NC + 4);

    // Single-column writes, including out-of-range addresses.
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].data);
      rx_bytes0.delete();
      run_frame(0, 1);
      check("vec_size", rx_bytes0.size(), NC + 4);
      check("vec_col", int'(rx_bytes0[3 + vecs[i].chk_col]), int'(vecs[i].chk_val));
    end

    // Ramp pattern at 1 clock/bit, then 4 clocks/bit.
    for (int i = 0; i < NC; i++) wr(5'(i), 7'(i));
    run_frame(0, 1);
    run_frame(1, 4);

    // Writes and a send while busy: frame A unchanged, B restarts after 1 idle bit.
    for (int i = 0; i < NC; i++) wr(5'(i), 7'h55);
    start(0, k);
    while (cyc < k + 50) tick;
    for (int i = 0; i < NC; i++) wr(5'(i), 7'h2A);
    push_frame(0);
    send1 = 1'b1;
    tick;
    send1 = 1'b0;
    wait_done(0, 1, t, gap);
    check("a_done_latency", t - k, 321);
    check("a_busy_gap", int'(gap), 0);
    check("gap_done", int'(done1), 1);
    check("gap_busy", int'(busy1), 0);
    check("gap_txd", int'(txd1), 1);
    tick;
    check("b_start_bit", int'(txd1), 0);
    check("b_busy", int'(busy1), 1);
    check("b_done_low", int'(done1), 0);
    wait_done(0, 1, t2, gap);
    check("b_done_latency", t2 - t, 321);
    check("b_sb_drained", exp_q0.size(), 0);

    // Write in the same cycle as packet start goes out only in the next packet.
    tick;
    push_frame(0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 7'h11; send1 = 1'b1;
    tick;
    wr_en = 1'b0; send1 = 1'b0;
    model[0] = 7'h11;
    k = cyc;
    // Send sampled on the same edge done rises.
    while (cyc < k + 320) tick;
    push_frame(0);
    send1 = 1'b1;
    tick;
    send1 = 1'b0;
    check("sd_done", int'(done1), 1);
    check("sd_busy", int'(busy1), 0);
    check("sd_txd", int'(txd1), 1);
    tick;
    check("sd_restart_txd", int'(txd1), 0);
    check("sd_restart_busy", int'(busy1), 1);
    wait_done(0, 1, t, gap);
    check("sd_done_latency", t - (k + 321), 321);
    check("sd_sb_drained", exp_q0.size(), 0);
    repeat (3) tick;

    // Abort mid-DATA with asynchronous reset.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int c = 0; c < NC; c++) model[c] = '0;
    tick;
    wr(5'd7, 7'h05);
    start(0, k);
    while (cyc < k + 102) tick;
    check("abort_pre_bit0", int'(txd1), 1);
    tick;
    check("abort_pre_bit1", int'(txd1), 0);
    #1 reset = 1'b1;
    #1;
    check("abort_txd", int'(txd1), 1);
    check("abort_busy", int'(busy1), 0);
    check("abort_done", int'(done1), 0);
    exp_q0.delete();
    repeat (2) tick;
    reset = 1'b0;
    for (int c = 0; c < NC; c++) model[c] = '0;
    dc = 0;
    for (int n = 0; n < 40; n++) begin
      tick;
      if (done1) dc++;
    end
    check("abort_no_done", dc, 0);
    wr(5'd3, 7'h3C);
    rx_bytes0.delete();
    run_frame(0, 1);
    check("post_abort_size", rx_bytes0.size(), NC + 4);
    check("post_abort_col3", int'(rx_bytes0[6]), 8'h3C);

    repeat (5) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
